// File: rtl/tdm_demultiplexer_if.sv
// rtl/tdm_demultiplexer_if.sv - serial TDM link inputs and per-channel parallel outputs
interface tdm_demultiplexer_if #(
  parameter int WIDTH = 8
);
  logic             sample_en;
  logic             in;
  logic             frame;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             valid;
  logic             sync_err;
  logic             address0;
  logic             address1;

  // master drives the serial link, slave is the demultiplexer
  modport master (
    output sample_en, in, frame,
    input  out0, out1, out2, out3, valid, sync_err, address0, address1
  );

  modport slave (
    input  sample_en, in, frame,
    output out0, out1, out2, out3, valid, sync_err, address0, address1
  );
endinterface

// File: rtl/tdm_demultiplexer.sv
// rtl/tdm_demultiplexer.sv - four-channel TDM receive demultiplexer with frame alignment
module tdm_demultiplexer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tdm_demultiplexer_if.slave   bus
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {HUNT, LOCK} state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q [4];
  logic [WIDTH-1:0] sh_d [4];
  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             first_sample;
  logic             last_sample;

  // slot 0 / bit 0 in LOCK is only reachable right after a completed frame
  assign first_sample = (state_q == LOCK) && (slot_q == 2'd0) && (bit_q == '0);
  assign last_sample  = (slot_q == 2'd3) && (bit_q == BW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (bus.sample_en) begin
      unique case (state_q)
        HUNT: begin
          if (bus.frame) begin
            sh_d[0] = {sh_q[0][WIDTH-2:0], bus.in};
            slot_d  = 2'd1;
            bit_d   = '0;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (first_sample && !bus.frame) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (!first_sample && bus.frame) begin
            // early marker restarts alignment on this very sample
            err_d   = 1'b1;
            sh_d[0] = {sh_q[0][WIDTH-2:0], bus.in};
            slot_d  = 2'd1;
            bit_d   = '0;
          end else begin
            sh_d[slot_q] = {sh_q[slot_q][WIDTH-2:0], bus.in};
            slot_d       = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              bit_d = bit_q + 1'b1;
            end
            if (last_sample) begin
              for (int i = 0; i < 4; i++) begin
                out_d[i] = sh_d[i];
              end
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      bit_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_q[i]  <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) begin
        sh_q[i]  <= sh_d[i];
        out_q[i] <= out_d[i];
      end
    end
  end

  assign bus.out0     = out_q[0];
  assign bus.out1     = out_q[1];
  assign bus.out2     = out_q[2];
  assign bus.out3     = out_q[3];
  assign bus.valid    = valid_q;
  assign bus.sync_err = err_q;
  assign bus.address0 = slot_q[0];
  assign bus.address1 = slot_q[1];
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb/tb_tdm_demultiplexer.sv - randomized and directed checks against a sample-index frame model
module tb_tdm_demultiplexer;
  localparam int W = 8;
  localparam int FS = 4 * W;

  logic clk;
  logic reset;

  tdm_demultiplexer_if #(.WIDTH(W)) bus ();

  tdm_demultiplexer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;

  // model: sample index within frame, words gathered by (channel, bit position)
  bit         m_locked;
  int         m_k;
  logic [W-1:0] m_buf [4];
  logic [W-1:0] m_out [4];
  logic       m_valid;
  logic       m_err;
  logic [1:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_put(input int k, input logic din);
    m_buf[k % 4][W - 1 - k / 4] = din;
  endtask

  task automatic model_step(input logic r, input logic en, input logic frm, input logic din);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_k = 0;
      for (int i = 0; i < 4; i++) begin
        m_buf[i] = '0;
        m_out[i] = '0;
      end
    end else if (en) begin
      if (!m_locked) begin
        if (frm) begin
          m_locked = 1'b1;
          model_put(0, din);
          m_k = 1;
        end
      end else if (m_k == 0 && !frm) begin
        m_err = 1'b1;
        m_locked = 1'b0;
      end else if (m_k != 0 && frm) begin
        m_err = 1'b1;
        model_put(0, din);
        m_k = 1;
      end else begin
        model_put(m_k, din);
        m_k++;
        if (m_k == FS) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_buf[i];
          m_valid = 1'b1;
          m_k = 0;
        end
      end
    end
    m_addr = m_locked ? 2'(m_k % 4) : 2'd0;
  endtask

  task automatic cycle(input logic r, input logic en, input logic frm, input logic din);
    reset         = r;
    bus.sample_en = en;
    bus.frame     = frm;
    bus.in        = din;
    @(posedge clk);
    model_step(r, en, frm, din);
    @(negedge clk);
    cyc++;
    chk("valid", 32'(bus.valid), 32'(m_valid));
    chk("sync_err", 32'(bus.sync_err), 32'(m_err));
    chk("address", 32'({bus.address1, bus.address0}), 32'(m_addr));
    chk("out0", 32'(bus.out0), 32'(m_out[0]));
    chk("out1", 32'(bus.out1), 32'(m_out[1]));
    chk("out2", 32'(bus.out2), 32'(m_out[2]));
    chk("out3", 32'(bus.out3), 32'(m_out[3]));
    if (bus.valid) begin
      nvalid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
    end
    if (bus.sync_err) nerr++;
  endtask

  // ws holds ch0 in the top byte; nsamp < FS sends only a frame prefix
  task automatic send_frame(input logic [FS-1:0] ws, input bit mark, input bit stall, input int nsamp);
    for (int k = 0; k < nsamp; k++) begin
      int c;
      int b;
      c = k % 4;
      b = W - 1 - k / 4;
      cycle(1'b0, 1'b1, (k == 0) ? mark : 1'b0, ws[(3 - c) * W + b]);
      if (stall) cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic chk_outs(input string name, input logic [FS-1:0] ws);
    chk(name, {bus.out0, bus.out1, bus.out2, bus.out3}, ws);
  endtask

  localparam logic [FS-1:0] FA = {8'hA5, 8'h3C, 8'hFF, 8'h00};
  localparam logic [FS-1:0] FB = {8'h01, 8'h80, 8'h55, 8'hAA};
  localparam logic [FS-1:0] FC = {8'h96, 8'h0F, 8'h7E, 8'hC3};

  initial begin
    int c0;
    logic [FS-1:0] ws;
    bit mark;
    reset = 1'b1;
    bus.sample_en = 1'b0;
    bus.frame = 1'b0;
    bus.in = 1'b0;
    @(negedge clk);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("reset_outs", '0);
    chk("reset_addr", 32'({bus.address1, bus.address0}), 32'd0);

    nvalid = 0; nerr = 0; c0 = cyc + 1;
    send_frame(FA, 1'b1, 1'b0, FS);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_nvalid", nvalid, 1);
    chk("single_latency", last_vcyc - c0, FS - 1);
    chk("single_nerr", nerr, 0);
    chk_outs("single_outs", FA);

    nvalid = 0; nerr = 0; c0 = cyc + 1;
    send_frame(FA, 1'b1, 1'b1, FS);
    chk("stall_nvalid", nvalid, 1);
    chk("stall_latency", last_vcyc - c0, 2 * FS - 2);
    chk_outs("stall_outs", FA);

    nvalid = 0; nerr = 0;
    send_frame(FA, 1'b1, 1'b0, FS);
    send_frame(FB, 1'b1, 1'b0, FS);
    chk("b2b_nvalid", nvalid, 2);
    chk("b2b_spacing", last_vcyc - prev_vcyc, FS);
    chk("b2b_nerr", nerr, 0);
    chk_outs("b2b_outs", FB);

    nvalid = 0; nerr = 0;
    send_frame(FC, 1'b1, 1'b0, 10);
    send_frame(FA, 1'b1, 1'b0, FS);
    chk("early_nerr", nerr, 1);
    chk("early_nvalid", nvalid, 1);
    chk_outs("early_outs", FA);

    nvalid = 0; nerr = 0;
    send_frame(FB, 1'b1, 1'b0, FS);
    send_frame(FC, 1'b0, 1'b0, FS);
    chk("miss_nerr", nerr, 1);
    chk("miss_nvalid", nvalid, 1);
    chk_outs("miss_hold", FB);
    send_frame(FC, 1'b1, 1'b0, FS);
    chk_outs("miss_recover", FC);

    nvalid = 0; nerr = 0;
    send_frame(FA, 1'b1, 1'b0, 17);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk_outs("rst_mid_outs", '0);
    chk("rst_mid_addr", 32'({bus.address1, bus.address0}), 32'd0);
    chk("rst_mid_flags", nvalid + nerr, 0);
    send_frame(FB, 1'b1, 1'b0, FS);
    chk_outs("rst_mid_fresh", FB);

    for (int f = 0; f < 60; f++) begin
      ws = FS'($urandom);
      mark = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < FS; k++) begin
        while ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom));
        cycle($urandom_range(0, 499) == 0, 1'b1,
              (k == 0) ? mark : ($urandom_range(0, 199) == 0),
              ws[(3 - k % 4) * W + (W - 1 - k / 4)]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
